// File: rtl/sm83_fetch_if.sv
// sm83_fetch_if: fetch, decode and execute handshake bundle around sm83_fetch_seq
interface sm83_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  instr_o;
  logic        instr_valid;
  logic        is_instr16_o;
  logic        dec_is_instr16;
  logic        dec_halt;
  logic        exec_start;
  logic        exec_done;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        irq_pending;
  logic        ime_i;
  logic        halted;
  logic [15:0] pc_o;
  modport master (
    output mem_req, mem_addr, instr_o, instr_valid, is_instr16_o, exec_start, halted, pc_o,
    input  mem_rdata, mem_ack, dec_is_instr16, dec_halt, exec_done, pc_load, pc_load_val,
           irq_pending, ime_i
  );
  modport slave (
    input  mem_req, mem_addr, instr_o, instr_valid, is_instr16_o, exec_start, halted, pc_o,
    output mem_rdata, mem_ack, dec_is_instr16, dec_halt, exec_done, pc_load, pc_load_val,
           irq_pending, ime_i
  );
endinterface

// File: rtl/sm83_fetch_seq.sv
// sm83_fetch_seq: SM83 opcode fetch/decode sequencer owning PC and IR (optional SM83_HALT_BUG_EN models the HALT bug)
module sm83_fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  sm83_fetch_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_pc, w_pc, w_inc;
  logic [7:0]  r_ir, w_ir;
  logic        r_cb, w_cb, w_exec, w_bug_take;
`ifdef SM83_HALT_BUG_EN
  logic        r_noinc;
  assign w_inc = r_noinc ? 16'd0 : 16'd1;
  assign w_bug_take = r_state == S_DECODE && !r_cb && !bus.dec_is_instr16 && bus.dec_halt &&
                      !bus.ime_i && bus.irq_pending;
  // one-shot flag: the fetch after a bugged HALT re-reads the same byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_noinc <= 1'b0;
    else r_noinc <= (r_state == S_FETCH && bus.mem_ack) ? 1'b0 : (w_bug_take ? 1'b1 : r_noinc);
`else
  logic        w_unused_ime;
  assign w_unused_ime = bus.ime_i;
  assign w_inc = 16'd1;
  assign w_bug_take = 1'b0;
`endif
  // state, PC, IR and CB flag registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 8'h00;
      r_cb    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc;
      r_ir    <= w_ir;
      r_cb    <= w_cb;
    end
  // next-state, register updates and the execute start strobe
  always_comb begin
    w_next = r_state;
    w_pc   = r_pc;
    w_ir   = r_ir;
    w_cb   = r_cb;
    w_exec = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH:
        if (bus.mem_ack) begin
          w_ir   = bus.mem_rdata;
          w_pc   = r_pc + w_inc;
          w_next = S_DECODE;
        end
      S_DECODE:
        if (bus.dec_is_instr16 && !r_cb) begin
          w_cb   = 1'b1;
          w_next = S_FETCH;
        end else if (bus.dec_halt && !r_cb) w_next = w_bug_take ? S_FETCH : S_HALT;
        else begin
          w_exec = 1'b1;
          w_cb   = 1'b0;
          w_next = S_EXEC;
        end
      S_EXEC: begin
        if (bus.pc_load) w_pc = bus.pc_load_val;
        if (bus.exec_done) w_next = S_FETCH;
      end
      S_HALT: if (bus.irq_pending) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end
  assign bus.mem_req      = r_state == S_FETCH;
  assign bus.mem_addr     = r_pc;
  assign bus.pc_o         = r_pc;
  assign bus.instr_o      = r_ir;
  assign bus.instr_valid  = r_state == S_DECODE;
  assign bus.is_instr16_o = r_state == S_DECODE && r_cb;
  assign bus.exec_start   = w_exec;
  assign bus.halted       = r_state == S_HALT;
endmodule

// File: tb/tb_sm83_fetch_seq.sv
// tb_sm83_fetch_seq: directed scoreboard bench for sm83_fetch_seq with a memory and decode stub
module tb_sm83_fetch_seq;
  typedef struct {logic [7:0] ir; logic cb; logic [15:0] pc;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int n_exec = 0;
  int e0;
  int wait_n = 0;
  int wait_cnt = 0;
  bit bad;
  exp_t q[$];
  logic [7:0] mem [0:65535];
  sm83_fetch_if bus ();
  sm83_fetch_seq #(.RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // memory: acks after wait_n wait cycles; decode stub: 0xCB prefix, 0x76 HALT
  assign bus.mem_ack        = bus.mem_req && wait_cnt >= wait_n;
  assign bus.mem_rdata      = mem[bus.mem_addr];
  assign bus.dec_is_instr16 = bus.instr_valid && !bus.is_instr16_o && bus.instr_o == 8'hCB;
  assign bus.dec_halt       = bus.instr_valid && !bus.is_instr16_o && bus.instr_o == 8'h76;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= 0;
    else wait_cnt <= (bus.mem_req && !bus.mem_ack) ? wait_cnt + 1 : 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // scoreboard: every decode strobe is compared against the oldest expected record
  always @(negedge clk) begin
    if (rst_n && bus.exec_start) n_exec++;
    if (rst_n && bus.instr_valid) begin
      if (q.size() == 0) check("unexpected_decode", {24'h0, bus.instr_o}, 32'h1ff);
      else begin
        exp_t e;
        e = q.pop_front();
        check("dec_ir", {24'h0, bus.instr_o}, {24'h0, e.ir});
        check("dec_cb", {31'h0, bus.is_instr16_o}, {31'h0, e.cb});
        check("dec_pc", {16'h0, bus.pc_o}, {16'h0, e.pc});
      end
    end
  end
  task automatic wait_exec(input string tag);
    int n = 0;
    while (!bus.exec_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, bus.exec_start}, 32'h1);
  endtask
  task automatic do_exec(input bit ld_a, input logic [15:0] va, input bit ld, input logic [15:0] v);
    @(negedge clk);
    if (ld_a) begin
      bus.pc_load = 1'b1;
      bus.pc_load_val = va;
      @(negedge clk);
    end
    bus.exec_done = 1'b1;
    bus.pc_load = ld;
    bus.pc_load_val = v;
    @(negedge clk);
    bus.exec_done = 1'b0;
    bus.pc_load = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0001] = 8'hCB;
    mem[16'h0002] = 8'h37;
    mem[16'hC000] = 8'h76;
    mem[16'hC001] = 8'hC3;
    mem[16'h0100] = 8'h76;
    bus.exec_done = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = 16'h0000;
    bus.irq_pending = 1'b0;
    bus.ime_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_addr", {16'h0, bus.mem_addr}, 32'h0);
    check("rst_pc", {16'h0, bus.pc_o}, 32'h0);
    check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("rst_halted", {31'h0, bus.halted}, 32'h0);
    q.push_back('{8'h00, 1'b0, 16'h0001});
    rst_n = 1'b1;
    @(negedge clk);
    check("c1_req", {31'h0, bus.mem_req}, 32'h1);
    check("c1_addr", {16'h0, bus.mem_addr}, 32'h0);
    @(negedge clk);
    check("c2_valid", {31'h0, bus.instr_valid}, 32'h1);
    check("c2_exec", {31'h0, bus.exec_start}, 32'h1);
    do_exec(1'b0, 16'h0, 1'b0, 16'h0);
    e0 = n_exec;
    q.push_back('{8'hCB, 1'b0, 16'h0002});
    q.push_back('{8'h37, 1'b1, 16'h0003});
    wait_exec("cb_exec");
    do_exec(1'b0, 16'h0, 1'b0, 16'h0);
    check("cb_one_exec", n_exec - e0, 32'h1);
    q.push_back('{8'h00, 1'b0, 16'h0004});
    wait_exec("redir_exec");
    wait_n = 3;
    do_exec(1'b0, 16'h0, 1'b1, 16'hC000);
    q.push_back('{8'h76, 1'b0, 16'hC001});
    bad = 1'b0;
    repeat (4) begin
      if (!bus.mem_req || bus.mem_addr != 16'hC000) bad = 1'b1;
      @(negedge clk);
    end
    check("ws_hold", {31'h0, bad}, 32'h0);
    wait_n = 0;
    check("halt_no_exec", {31'h0, bus.exec_start}, 32'h0);
    @(negedge clk);
    check("halt_on", {31'h0, bus.halted}, 32'h1);
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'hDEAD;
    bad = 1'b0;
    repeat (10) begin
      if (bus.mem_req || !bus.halted) bad = 1'b1;
      @(negedge clk);
    end
    bus.pc_load = 1'b0;
    check("halt_quiet", {31'h0, bad}, 32'h0);
    bus.irq_pending = 1'b1;
    @(negedge clk);
    bus.irq_pending = 1'b0;
    check("wake_req", {31'h0, bus.mem_req}, 32'h1);
    check("wake_addr", {16'h0, bus.mem_addr}, 32'hC001);
    check("wake_halted", {31'h0, bus.halted}, 32'h0);
    q.push_back('{8'hC3, 1'b0, 16'hC002});
    wait_exec("jp_exec");
    do_exec(1'b1, 16'h5555, 1'b1, 16'h0100);
    check("last_load_addr", {16'h0, bus.mem_addr}, 32'h0100);
    bus.ime_i = 1'b0;
    bus.irq_pending = 1'b1;
    q.push_back('{8'h76, 1'b0, 16'h0101});
    @(negedge clk);
`ifdef SM83_HALT_BUG_EN
    @(negedge clk);
    bus.irq_pending = 1'b0;
    check("hb_halted", {31'h0, bus.halted}, 32'h0);
    check("hb_addr1", {16'h0, bus.mem_addr}, 32'h0101);
    check("hb_req1", {31'h0, bus.mem_req}, 32'h1);
    q.push_back('{8'h00, 1'b0, 16'h0101});
    wait_exec("hb_exec1");
    do_exec(1'b0, 16'h0, 1'b0, 16'h0);
    check("hb_addr2", {16'h0, bus.mem_addr}, 32'h0101);
    check("hb_req2", {31'h0, bus.mem_req}, 32'h1);
`else
    @(negedge clk);
    check("nb_halted", {31'h0, bus.halted}, 32'h1);
    @(negedge clk);
    bus.irq_pending = 1'b0;
    check("nb_addr", {16'h0, bus.mem_addr}, 32'h0101);
    check("nb_req", {31'h0, bus.mem_req}, 32'h1);
`endif
    q.push_back('{8'h00, 1'b0, 16'h0102});
    bus.ime_i = 1'b1;
    wait_exec("post_halt_exec");
    do_exec(1'b0, 16'h0, 1'b1, 16'hFFFF);
    check("wrap_addr", {16'h0, bus.mem_addr}, 32'hFFFF);
    q.push_back('{8'h00, 1'b0, 16'h0000});
    wait_exec("wrap_exec");
    wait_n = 5;
    do_exec(1'b0, 16'h0, 1'b1, 16'h2000);
    check("mid_addr", {16'h0, bus.mem_addr}, 32'h2000);
    @(negedge clk);
    check("mid_req", {31'h0, bus.mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'h0, bus.mem_req}, 32'h0);
    check("arst_pc", {16'h0, bus.pc_o}, 32'h0);
    check("arst_addr", {16'h0, bus.mem_addr}, 32'h0);
    repeat (2) @(negedge clk);
    wait_n = 0;
    q.push_back('{8'h00, 1'b0, 16'h0001});
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req", {31'h0, bus.mem_req}, 32'h1);
    check("post_rst_addr", {16'h0, bus.mem_addr}, 32'h0);
    wait_exec("post_rst_exec");
    do_exec(1'b0, 16'h0, 1'b0, 16'h0);
    check("sb_empty", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm83_fetch_seq.md
Name: sm83_fetch_seq

Overview:
- Opcode fetch/decode sequencer for the SM83 core.
- Owns the PC and the instruction register, and runs the memory fetch handshake.
- Drives the decode stage's instruction input and its CB-prefix input, and gates the execute stage start.
- Handles the CB-prefix two-byte fetch, HALT entry/wake, and PC redirects from execute.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (boot ROM base).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  fetch request; address held stable until acked.
- mem_addr  out  16  fetch address (= current PC).
- mem_rdata  in  8  fetched byte; valid when mem_ack=1.
- mem_ack  in  1  fetch complete; sampled only while mem_req=1.
- instr_o  out  8  instruction register, to decode.
- instr_valid  out  1  decode cycle strobe.
- is_instr16_o  out  1  to decode i_is_instr16: current byte is the CB-suffix byte.
- dec_is_instr16  in  1  from decode: current byte is the CB prefix.
- dec_halt  in  1  from decode: ctl_op is HALT.
- exec_start  out  1  one-cycle pulse starting execute of the decoded op.
- exec_done  in  1  execute finished (single-cycle pulse).
- pc_load  in  1  PC redirect from execute.
- pc_load_val  in  16  redirect target.
- irq_pending  in  1  enabled interrupt flag pending (IE & IF != 0).
- ime_i  in  1  interrupt master enable.
- halted  out  1  high while in HALT.
- pc_o  out  16  current PC.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset (async, any state, including mid-fetch):
  - State goes to IDLE; pc=RESET_PC; ir=8'h00; cb flag=0.
  - All outputs 0 except mem_addr/pc_o=RESET_PC.
  - Any pending request is abandoned; a late mem_ack is ignored.
- IDLE: one cycle, then FETCH.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: ir<=mem_rdata; pc<=pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000); go to DECODE.
  - Zero-wait memory (ack in the first FETCH cycle) gives a 1-cycle fetch.
- DECODE: instr_valid=1 for exactly one cycle; is_instr16_o=cb flag. Priority order:
  - dec_is_instr16 (only meaningful while cb flag=0): cb flag<=1, go to FETCH; no exec_start.
  - Else dec_halt and cb flag=0: go to HALT.
  - Else: exec_start=1 this cycle, cb flag<=0, go to EXEC.
- EXEC:
  - Wait for exec_done, then go to FETCH.
  - pc_load in any EXEC cycle sets pc<=pc_load_val; the last load wins.
  - pc_load and exec_done in the same cycle: the load applies, and the next FETCH uses the new PC.
  - pc_load outside EXEC is ignored.
- HALT:
  - halted=1, mem_req=0, PC frozen.
  - irq_pending=1 goes to FETCH on the next edge, independent of ime_i.
  - Interrupt dispatch is out of scope.
- Minimum per-instruction cycles: FETCH 1 + DECODE 1 + EXEC ≥1. A CB instruction adds one FETCH + DECODE pair.
- CB flag persists only across the prefix→suffix fetch. A CB-suffix byte is never interpreted as HALT or prefix.

Optional Feature:
- Macro: SM83_HALT_BUG_EN.
- Defined:
  - In DECODE, with dec_halt, ime_i=0 and irq_pending=1: HALT is not entered; go to FETCH with a one-shot "no-increment" flag set.
  - The next fetch acks without incrementing pc, so the byte after HALT is read twice (hardware HALT bug).
  - The flag clears on that ack or on reset.
- Undefined: HALT is always entered; wake happens per HALT rules.

Test Plan:
- Reset: mem_addr=0x0000, mem_req=0. Zero-wait memory returns 0x00 (NOP) at 0x0000 → mem_req at cycle 1, instr_valid at cycle 2 with instr_o=0x00, exec_start at cycle 2, pc=0x0001.
- Prefix: mem returns 0xCB then 0x37 with dec_is_instr16 on the first byte → two DECODE strobes; second has is_instr16_o=1 and instr_o=0x37; exactly one exec_start; pc advances by 2.
- Redirect and wait states: pc_load=1 with pc_load_val=0xC000 in the same cycle as exec_done → next mem_addr=0xC000. With mem_ack delayed 3 cycles, mem_addr stays 0xC000 and mem_req stays 1 throughout.
- HALT: dec_halt with irq_pending=0 → halted=1, no mem_req for 10 cycles; raise irq_pending → FETCH next cycle at pc (HALT address + 1).
- Wrap and reset: fetch at pc=0xFFFF → pc=0x0000. Assert rst_n=0 mid-FETCH with ack pending → mem_req drops immediately, pc=RESET_PC.
- SM83_HALT_BUG_EN: HALT at 0x0100, ime_i=0, irq_pending=1 → halted stays 0; two consecutive fetches at 0x0101. Without the macro, a single fetch at 0x0101 after one HALT cycle.
